io_port_responder: RTL and testbench

- Device-side responder for the multicycle processor's I/O instructions (opcode 4'b1100; funk==1 is `in`, otherwise `out`).
- `out` state: the control unit pulses OutputWrite. This block queues the register word in a small FIFO and drains it to an external device over a valid/ready handshake.
- `in` state: the control unit writes InData to the register file. This block holds one word captured from the external device and returns it on that cycle.
- Sits between the datapath's I/O mux input / output register and the board-level peripheral.

---
 rtl/io_port_responder_if.sv | 23 ++
 rtl/io_port_responder.sv | 119 +++++++++++
 tb/tb_io_port_responder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/io_port_responder_if.sv
// Device-side handshake bundle for io_port_responder.
// master: the responder (drives out_valid/out_data/in_ready).
// slave : the board-level peripheral (drives out_ready/in_valid/in_data).
interface io_port_responder_if #(
    parameter int unsigned DATA_W = 16
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master (
        output out_valid, out_data, in_ready,
        input  out_ready, in_valid, in_data
    );

    modport slave (
        input  out_valid, out_data, in_ready,
        output out_ready, in_valid, in_data
    );
endinterface

// File: rtl/io_port_responder.sv
// Device-side responder for the processor's in/out instructions.
// Ports:
//   CLK, Reset        clock (rising edge), async active-low reset
//   OutputWrite/OutData  push a register word into the output FIFO
//   InRead/InData     consume the held input word (InData=0 when empty)
//   ClearErr          clears the sticky overflow/underflow flags
//   out_count, in_full, overflow, underflow  status
//   dev               device handshake (valid/ready out FIFO, valid/ready in hold)
module io_port_responder #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned OUT_DEPTH = 4,
    parameter int unsigned PTR_W     = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              OutputWrite,
    input  logic [DATA_W-1:0] OutData,
    input  logic              InRead,
    output logic [DATA_W-1:0] InData,
    output logic [PTR_W:0]    out_count,
    output logic              in_full,
    output logic              overflow,
    output logic              underflow,
    input  logic              ClearErr,
    io_port_responder_if.master dev
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(OUT_DEPTH);

    logic [DATA_W-1:0] r_mem [OUT_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic [DATA_W-1:0] r_hold;
    logic              r_in_full;
    logic              r_overflow;
    logic              r_underflow;

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_ovf_set;
    logic w_unf_set;
    logic w_capture;
    logic w_consume;

    // FIFO handshake; a pop frees the slot a full-FIFO push needs
    assign w_full    = (r_count == FULL_CNT);
    assign w_pop     = (r_count != '0) && dev.out_ready;
    assign w_push    = OutputWrite && (!w_full || w_pop);
    assign w_ovf_set = OutputWrite && !w_push;

    // Holding register; capture needs !full and consume needs full, so they never collide
    assign w_capture = dev.in_valid && !r_in_full;
    assign w_consume = InRead && r_in_full;
    assign w_unf_set = InRead && !r_in_full;

    assign dev.out_valid = (r_count != '0);
    assign dev.out_data  = r_mem[r_rd_ptr];
    assign dev.in_ready  = !r_in_full;
    assign InData        = r_in_full ? r_hold : '0;
    assign out_count     = r_count;
    assign in_full       = r_in_full;
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

    // FIFO storage; contents are don't-care once pointers reset
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= OutData;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at 2**PTR_W
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PTR_W+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (PTR_W+1)'(1);
            end
        end
    end

    // Input holding register
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_hold    <= '0;
            r_in_full <= 1'b0;
        end else begin
            if (w_capture) begin
                r_hold    <= dev.in_data;
                r_in_full <= 1'b1;
            end else if (w_consume) begin
                r_in_full <= 1'b0;
            end
        end
    end

    // Sticky error flags; a set wins over a same-cycle clear
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  && !ClearErr) || w_ovf_set;
            r_underflow <= (r_underflow && !ClearErr) || w_unf_set;
        end
    end
endmodule

// File: tb/tb_io_port_responder.sv
// Self-checking bench for io_port_responder: directed scenarios plus random
// traffic, all compared against a queue-based behavioural model.
module tb_io_port_responder;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned OUT_DEPTH = 4;
    localparam int unsigned PTR_W     = 2;

    logic              CLK;
    logic              Reset;
    logic              OutputWrite;
    logic [DATA_W-1:0] OutData;
    logic              InRead;
    logic [DATA_W-1:0] InData;
    logic [PTR_W:0]    out_count;
    logic              in_full;
    logic              overflow;
    logic              underflow;
    logic              ClearErr;

    io_port_responder_if #(.DATA_W(DATA_W)) dev_if ();

    io_port_responder #(
        .DATA_W(DATA_W), .OUT_DEPTH(OUT_DEPTH), .PTR_W(PTR_W)
    ) dut (
        .CLK(CLK), .Reset(Reset),
        .OutputWrite(OutputWrite), .OutData(OutData),
        .InRead(InRead), .InData(InData),
        .out_count(out_count), .in_full(in_full),
        .overflow(overflow), .underflow(underflow),
        .ClearErr(ClearErr),
        .dev(dev_if.master)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] m_hold;
    bit                m_full;
    bit                m_ovf;
    bit                m_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_hold = '0;
        m_full = 0;
        m_ovf  = 0;
        m_unf  = 0;
    endtask

    // Compare every visible output with what the model says it should be now
    task automatic compare_all();
        check("out_valid", 32'(dev_if.out_valid), 32'(m_q.size() != 0));
        check("out_count", 32'(out_count), 32'(m_q.size()));
        if (m_q.size() != 0) check("out_data", 32'(dev_if.out_data), 32'(m_q[0]));
        check("in_ready", 32'(dev_if.in_ready), 32'(!m_full));
        check("in_full", 32'(in_full), 32'(m_full));
        check("InData", 32'(InData), m_full ? 32'(m_hold) : 32'd0);
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
    endtask

    // Advance the model across one clock edge using the currently driven inputs
    task automatic model_step();
        bit pop, push, cap, ovf_set, unf_set;
        pop     = (m_q.size() != 0) && dev_if.out_ready;
        push    = OutputWrite && ((m_q.size() < OUT_DEPTH) || pop);
        ovf_set = OutputWrite && !push;
        cap     = dev_if.in_valid && !m_full;
        unf_set = InRead && !m_full;
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(OutData);
        if (cap) begin
            m_hold = dev_if.in_data;
            m_full = 1;
        end else if (InRead && m_full) begin
            m_full = 0;
        end
        m_ovf = (m_ovf && !ClearErr) || ovf_set;
        m_unf = (m_unf && !ClearErr) || unf_set;
    endtask

    task automatic drive_idle();
        OutputWrite      = 1'b0;
        OutData          = '0;
        InRead           = 1'b0;
        ClearErr         = 1'b0;
        dev_if.out_ready = 1'b0;
        dev_if.in_valid  = 1'b0;
        dev_if.in_data   = '0;
    endtask

    // Drive one cycle of inputs, check outputs, then step the model
    task automatic cycle(input logic ow, input logic [DATA_W-1:0] od, input logic ir,
                         input logic ordy, input logic iv, input logic [DATA_W-1:0] idat,
                         input logic clr);
        @(negedge CLK);
        OutputWrite      = ow;
        OutData          = od;
        InRead           = ir;
        dev_if.out_ready = ordy;
        dev_if.in_valid  = iv;
        dev_if.in_data   = idat;
        ClearErr         = clr;
        #1;
        compare_all();
        model_step();
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, 1'b0, ordy, 1'b0, '0, 1'b0);
    endtask

    initial begin
        drive_idle();
        model_reset();
        Reset = 1'b0;
        repeat (2) @(negedge CLK);
        Reset = 1'b1;
        idle(1'b0);

        // Push two words while the device stalls, then drain them
        cycle(1'b1, 16'h00A1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("first_push_no_bypass", 32'(dev_if.out_valid), 32'd0);
        cycle(1'b1, 16'h00A2, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("valid_after_push", 32'(dev_if.out_valid), 32'd1);
        idle(1'b0);
        check("count_two", 32'(out_count), 32'd2);
        check("head_a1_held", 32'(dev_if.out_data), 32'h00A1);
        idle(1'b1);
        check("drain_a1", 32'(dev_if.out_data), 32'h00A1);
        idle(1'b1);
        check("drain_a2", 32'(dev_if.out_data), 32'h00A2);
        idle(1'b1);
        check("drained_empty", 32'(dev_if.out_valid), 32'd0);

        // Fill, overflow, drain in order, clear
        for (int i = 1; i <= 4; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        idle(1'b0);
        check("ovf_count4", 32'(out_count), 32'd4);
        check("ovf_set", 32'(overflow), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            idle(1'b1);
            check("ovf_drain_order", 32'(dev_if.out_data), 32'(i));
        end
        idle(1'b0);
        check("ovf_no_dead", 32'(dev_if.out_valid), 32'd0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        idle(1'b0);
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO with simultaneous push and pop
        for (int i = 1; i <= 4; i++) cycle(1'b1, 16'(16'h10 + i), 1'b0, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 16'h0055, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        idle(1'b0);
        check("pushpop_count4", 32'(out_count), 32'd4);
        check("pushpop_no_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("pushpop_last_55", 32'(dev_if.out_data), 32'h0055);
        idle(1'b0);

        // Input holding register: capture, back-pressure, consume, recapture
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 16'h5678, 1'b0);
        check("in_ready_drop", 32'(dev_if.in_ready), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 16'h5678, 1'b0);
        check("indata_1234", 32'(InData), 32'h1234);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 16'h5678, 1'b0);
        check("in_ready_back", 32'(dev_if.in_ready), 32'd1);
        idle(1'b0);
        check("indata_5678", 32'(InData), 32'h5678);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);

        // Underflow, clear, and set-beats-clear
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        check("unf_indata0", 32'(InData), 32'd0);
        idle(1'b0);
        check("unf_set", 32'(underflow), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        idle(1'b0);
        check("unf_cleared", 32'(underflow), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        idle(1'b0);
        check("unf_set_wins", 32'(underflow), 32'd1);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            cycle(1'($urandom_range(0, 99) < 45), 16'($urandom), 1'($urandom_range(0, 99) < 25),
                  1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 50), 16'($urandom),
                  1'($urandom_range(0, 99) < 5));
        end

        // Asynchronous reset mid-drain with three words queued
        cycle(0, '0, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0);
        while (m_q.size() != 0) idle(1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'(16'hC0 + i), 1'b0, 1'b0, 1'b0, '0, 1'b0);
        idle(1'b1);
        check("pre_reset_count3", 32'(out_count), 32'd3);
        @(posedge CLK);
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        check("rst_out_valid", 32'(dev_if.out_valid), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_in_ready", 32'(dev_if.in_ready), 32'd1);
        check("rst_indata", 32'(InData), 32'd0);
        drive_idle();
        @(negedge CLK);
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("post_reset_no_stale", 32'(dev_if.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
